spi_dma_wr: RTL and testbench
=============================

# spi_dma_wr

SPI-to-memory DMA writer, successor to the fixed 64-word SPI write path. It decodes a command byte from the SPI protocol wrapper and packs the following bytes into 16-bit words in a parametrised FIFO. Those words are burst into external memory through the MemIF command/write port. New relative to the previous generation: configurable burst length and FIFO depth, a ring-buffer address window with wrap, partial-burst flush on end of SPI transaction, overflow detection, and Wishbone status readback.

## Interface
- `CMD_BYTE`, 8'he0: SPI command byte that opens a write stream.
- `BURST_LEN`, 64: maximum burst in 16-bit words; power of 2, 2..128.
- `FIFO_DEPTH`, 256: FIFO depth in words; power of 2, ≥ 2·BURST_LEN.
- `ADDR_WIDTH`, 23: memory word-address width, ≤ 32.
- `clk` in 1: single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `pw_wdata` in 8: byte from the protocol wrapper.
- `pw_wcmd` in 1: byte is a command byte.
- `pw_wstb` in 1: byte strobe.
- `pw_end` in 1: SPI transaction end.
- `mi_addr` out 32: burst word address, zero-extended from ADDR_WIDTH.
- `mi_len` out 7: burst length minus 1.
- `mi_rw` out 1: tied 0 (write).
- `mi_valid` out 1: command valid.
- `mi_ready` in 1: command accepted.
- `mi_wdata` out 16: write data.
- `mi_wack` in 1: word consumed.
- `mi_wlast` in 1: last word of burst.
- `mi_rdata` in 16: unused.
- `mi_rstb` in 1: unused.
- `mi_rlast` in 1: unused.
- `wb_wdata` in 32, `wb_rdata` out 32, `wb_addr` in 2, `wb_we` in 1, `wb_cyc` in 1, `wb_ack` out 1: Wishbone register port.

## Operation
**Registers** (`wb_addr`):
- 0 CSR.
  - Write: [0] run, [1] wrap_en, [31] clear overflow when set to 1.
  - Read: [0] run, [1] wrap_en, [2] busy (state≠IDLE), [3] overflow, [31:16] FIFO level.
- 1 BASE: word address.
- 2 LIMIT: exclusive end word address.
- 3 CUR: write sets the current address; read returns it.

**SPI capture**
- Stream becomes active on `pw_wstb & pw_wcmd & pw_wdata==CMD_BYTE`; it ends on `pw_end`.
- Data bytes are packed big-endian: the first byte goes to [15:8], the second to [7:0], and the pair is written to the FIFO on the second strobe.
- An odd trailing byte at `pw_end` is discarded.
- A word arriving while the FIFO is full is dropped and sets the sticky overflow bit.

**DMA state machine**: IDLE → CMD → DATA → IDLE.
- IDLE → CMD when `run` and either:
  - level ≥ BURST_LEN, or
  - a flush is pending and level > 0.
- Latch n = min(level, BURST_LEN, LIMIT−CUR when wrap_en), with n ≥ 1.
- CMD: `mi_valid`=1, `mi_len`=n−1; go to DATA on `mi_ready`.
- DATA: each `mi_wack` pops one word. On `mi_wack & mi_wlast`, return to IDLE and update CUR.
- CUR update: CUR += n. If wrap_en and the new CUR ≥ LIMIT, CUR = BASE. Without wrap_en, CUR wraps modulo 2^ADDR_WIDTH.
- Flush pending:
  - Set by `pw_end` while the stream is active.
  - Cleared when the FIFO level reaches 0, either with no burst outstanding or at the end of a burst.
- Clearing `run` mid-burst completes the current burst; no new burst starts.
- Writes to CUR/BASE/LIMIT while state≠IDLE are applied but take effect at the next burst.

## Timing
- `wb_ack` = registered (`wb_cyc & ~wb_ack`): 1-cycle latency, then 1 idle cycle.
- Register writes take effect 2 cycles after `wb_cyc` rises.
- `wb_rdata` is valid with `wb_ack`.
- FIFO write occurs 1 cycle after the second byte strobe.
- Level is updated in the same cycle as the push/pop; simultaneous push and pop leaves the level unchanged.
- First `mi_valid` appears 2 cycles after the level reaches threshold.
- `mi_valid` holds until `mi_ready`; `mi_addr`/`mi_len` are stable while `mi_valid`.
- `mi_wdata` shows the FIFO head combinationally and advances the cycle after `mi_wack`. The FIFO is first-word-fall-through.
- Reset values (async on `rst_n` low):
  - `wb_ack`, `mi_valid`, run, wrap_en, overflow, flush: 0.
  - BASE, LIMIT, CUR: 0.
  - FIFO empty; state IDLE; stream inactive.
- A reset mid-burst abandons the burst immediately.

## Test plan
- **Full burst:** BASE=CUR=0x100, run=1, cmd 0xE0 + 128 bytes → one burst with `mi_addr`=0x100, `mi_len`=63. Data words are 0x0001, 0x0203, …; CUR=0x140.
- **Flush:** 10 bytes then `pw_end` → burst with `mi_len`=4 and 5 words. An 11th byte gives the same result (odd byte dropped).
- **Wrap:** BASE=0x1000, LIMIT=0x1050, CUR=0x1040, wrap_en=1, 128 bytes:
  - First burst: `mi_len`=15 at 0x1040.
  - Then CUR=0x1000.
  - Next burst: `mi_len`=47 at 0x1000.
- **Overflow:** run=0, FIFO_DEPTH+2 words sent → level=FIFO_DEPTH and CSR[3]=1. Write CSR bit31 → CSR[3]=0.
- **Handshake stress:** random `mi_ready`/`mi_wack` gaps with simultaneous SPI pushes → memory image matches the byte stream and no word is lost or duplicated.
- **Reset mid-burst:** assert `rst_n` low during DATA → `mi_valid`=0, level=0, all registers 0 on release.

Source files
------------

// File: rtl/spi_dma_wr.sv
// SPI-to-memory DMA writer.
// Command-framed SPI byte streams are packed big-endian into 16-bit words, buffered in a
// first-word-fall-through FIFO and burst into memory through the MemIF port inside a
// ring-buffer address window. A Wishbone port exposes control and status.
module spi_dma_wr #(
  parameter logic [7:0]  CMD_BYTE   = 8'he0,
  parameter int unsigned BURST_LEN  = 64,
  parameter int unsigned FIFO_DEPTH = 256,
  parameter int unsigned ADDR_WIDTH = 23
) (
  input  logic        clk,
  input  logic        rst_n,
  // protocol wrapper
  input  logic [7:0]  pw_wdata,
  input  logic        pw_wcmd,
  input  logic        pw_wstb,
  input  logic        pw_end,
  // memory interface
  output logic [31:0] mi_addr,
  output logic [6:0]  mi_len,
  output logic        mi_rw,
  output logic        mi_valid,
  input  logic        mi_ready,
  output logic [15:0] mi_wdata,
  input  logic        mi_wack,
  input  logic        mi_wlast,
  input  logic [15:0] mi_rdata,
  input  logic        mi_rstb,
  input  logic        mi_rlast,
  // Wishbone register port
  input  logic [31:0] wb_wdata,
  output logic [31:0] wb_rdata,
  input  logic [1:0]  wb_addr,
  input  logic        wb_we,
  input  logic        wb_cyc,
  output logic        wb_ack
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;

  typedef enum logic [1:0] {StIdle, StCmd, StData} state_e;

  // SPI capture
  logic                  r_active, r_half, r_push;
  logic [7:0]            r_hi;
  logic [15:0]           r_pword;
  logic                  w_byte2;
  // FIFO
  logic [15:0]           r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wptr, r_rptr;
  logic [LW-1:0]         r_level, w_level_next;
  logic                  w_full, w_wr, w_pop;
  // DMA
  state_e                r_state, w_state_d;
  logic                  r_start, w_start_cond, w_latch, w_done;
  logic [7:0]            r_n, w_n, w_len;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [32:0]           w_cand, w_room, w_sum;
  logic [ADDR_WIDTH-1:0] w_cur_next;
  // registers
  logic                  r_run, r_wrap, r_ovf, r_flush, r_cur_wr;
  logic [ADDR_WIDTH-1:0] r_base, r_limit, r_cur;
  logic                  r_ack, w_wb_wr, w_busy;
  logic [31:0]           r_rdata, w_rd;
  logic                  w_unused;

  assign w_unused = ^{mi_rdata, mi_rstb, mi_rlast, w_len[7]};

  // Second byte of a pair inside an active stream; pw_end wins over a same-cycle strobe.
  assign w_byte2 = ~pw_end & pw_wstb & ~pw_wcmd & r_active & r_half;

  // Stream framing and big-endian byte pairing; the packed word is pushed one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_half   <= 1'b0;
      r_hi     <= 8'd0;
      r_push   <= 1'b0;
      r_pword  <= 16'd0;
    end else begin
      r_push <= w_byte2;
      if (w_byte2) r_pword <= {r_hi, pw_wdata};
      if (pw_end) begin
        r_active <= 1'b0;
        r_half   <= 1'b0;
      end else if (pw_wstb) begin
        if (pw_wcmd) begin
          r_active <= (pw_wdata == CMD_BYTE);
          r_half   <= 1'b0;
        end else if (r_active) begin
          if (!r_half) r_hi <= pw_wdata;
          r_half <= ~r_half;
        end
      end
    end
  end

  assign w_full       = (r_level == LW'(FIFO_DEPTH));
  assign w_wr         = r_push & ~w_full;
  assign w_pop        = (r_state == StData) & mi_wack & (r_level != '0);
  assign w_level_next = r_level + LW'(w_wr) - LW'(w_pop);
  assign mi_wdata     = r_mem[r_rptr];

  // FIFO storage (no reset needed, validity tracked by level)
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= r_pword;
  end

  // FIFO pointers and level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + PW'(1);
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      r_level <= w_level_next;
    end
  end

  assign w_start_cond = r_run & ((r_level >= LW'(BURST_LEN)) | (r_flush & (r_level != '0)));

  // Burst size: min(level, BURST_LEN, room to LIMIT when wrapping), never below one word.
  always_comb begin
    w_room = '0;
    w_cand = 33'(r_level);
    if (w_cand > 33'(BURST_LEN)) w_cand = 33'(BURST_LEN);
    if (r_wrap) begin
      if (r_cur < r_limit) w_room = 33'(r_limit) - 33'(r_cur);
      if (w_room < w_cand) w_cand = w_room;
    end
    if (w_cand == '0) w_cand = 33'd1;
    w_n = w_cand[7:0];
  end

  // DMA state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  // DMA next state and command valid
  always_comb begin
    w_state_d = r_state;
    mi_valid  = 1'b0;
    w_latch   = 1'b0;
    w_done    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (r_start && w_start_cond) begin
          w_state_d = StCmd;
          w_latch   = 1'b1;
        end
      end
      StCmd: begin
        mi_valid = 1'b1;
        if (mi_ready) w_state_d = StData;
      end
      StData: begin
        if (mi_wack && mi_wlast) begin
          w_state_d = StIdle;
          w_done    = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Start is qualified one cycle before the burst is latched, giving a two-cycle response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start <= 1'b0;
      r_addr  <= '0;
      r_n     <= 8'd1;
    end else begin
      r_start <= (r_state == StIdle) & w_start_cond;
      if (w_latch) begin
        r_addr <= r_cur;
        r_n    <= w_n;
      end
    end
  end

  assign w_len   = r_n - 8'd1;
  assign mi_len  = w_len[6:0];
  assign mi_addr = 32'(r_addr);
  assign mi_rw   = 1'b0;
  assign w_busy  = (r_state != StIdle);

  assign w_sum      = 33'(r_cur) + 33'(r_n);
  assign w_cur_next = (r_wrap && (w_sum >= 33'(r_limit))) ? r_base : w_sum[ADDR_WIDTH-1:0];
  assign w_wb_wr    = wb_cyc & wb_we & r_ack;

  // Control registers; a CUR write during a burst takes precedence over the end-of-burst advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run    <= 1'b0;
      r_wrap   <= 1'b0;
      r_base   <= '0;
      r_limit  <= '0;
      r_cur    <= '0;
      r_cur_wr <= 1'b0;
    end else begin
      if (w_wb_wr) begin
        unique case (wb_addr)
          2'd0: begin
            r_run  <= wb_wdata[0];
            r_wrap <= wb_wdata[1];
          end
          2'd1: r_base  <= wb_wdata[ADDR_WIDTH-1:0];
          2'd2: r_limit <= wb_wdata[ADDR_WIDTH-1:0];
          2'd3: r_cur   <= wb_wdata[ADDR_WIDTH-1:0];
        endcase
      end
      if (w_done && !r_cur_wr && !(w_wb_wr && wb_addr == 2'd3)) r_cur <= w_cur_next;
      if (w_done)                                          r_cur_wr <= 1'b0;
      else if (w_wb_wr && wb_addr == 2'd3 && w_busy)       r_cur_wr <= 1'b1;
    end
  end

  // Sticky overflow and flush-pending flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf   <= 1'b0;
      r_flush <= 1'b0;
    end else begin
      if (r_push && w_full)                              r_ovf <= 1'b1;
      else if (w_wb_wr && wb_addr == 2'd0 && wb_wdata[31]) r_ovf <= 1'b0;
      if (pw_end && r_active)                                        r_flush <= 1'b1;
      else if ((r_state == StIdle || w_done) && w_level_next == '0)  r_flush <= 1'b0;
    end
  end

  // Readback mux
  always_comb begin
    w_rd = '0;
    unique case (wb_addr)
      2'd0: w_rd = {16'(r_level), 12'd0, r_ovf, w_busy, r_wrap, r_run};
      2'd1: w_rd = 32'(r_base);
      2'd2: w_rd = 32'(r_limit);
      2'd3: w_rd = 32'(r_cur);
    endcase
  end

  // Wishbone ack pulse with read data captured alongside
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack <= wb_cyc & ~r_ack;
      if (wb_cyc && !r_ack) r_rdata <= w_rd;
    end
  end

  assign wb_ack   = r_ack;
  assign wb_rdata = r_rdata;

endmodule

// File: tb/tb_spi_dma_wr.sv
// Self-checking bench for spi_dma_wr: a word-queue/address model plus a MemIF responder
// that checks every burst command and written word, with directed scenarios on top.
module tb_spi_dma_wr;
  localparam int BL = 64;
  localparam int FD = 256;
  localparam int AW = 23;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  pw_wdata;
  logic        pw_wcmd, pw_wstb, pw_end;
  logic [31:0] mi_addr;
  logic [6:0]  mi_len;
  logic        mi_rw, mi_valid, mi_ready;
  logic [15:0] mi_wdata;
  logic        mi_wack, mi_wlast;
  logic [31:0] wb_wdata, wb_rdata;
  logic [1:0]  wb_addr;
  logic        wb_we, wb_cyc, wb_ack;

  spi_dma_wr #(.CMD_BYTE(8'he0), .BURST_LEN(BL), .FIFO_DEPTH(FD), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .pw_wdata(pw_wdata), .pw_wcmd(pw_wcmd), .pw_wstb(pw_wstb), .pw_end(pw_end),
    .mi_addr(mi_addr), .mi_len(mi_len), .mi_rw(mi_rw), .mi_valid(mi_valid),
    .mi_ready(mi_ready), .mi_wdata(mi_wdata), .mi_wack(mi_wack), .mi_wlast(mi_wlast),
    .mi_rdata(16'h0000), .mi_rstb(1'b0), .mi_rlast(1'b0),
    .wb_wdata(wb_wdata), .wb_rdata(wb_rdata), .wb_addr(wb_addr), .wb_we(wb_we),
    .wb_cyc(wb_cyc), .wb_ack(wb_ack)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: expected word stream and address bookkeeping
  logic [15:0] exp_q[$];
  bit          m_active, m_have, m_cap, m_wrap;
  logic [7:0]  m_hi;
  logic [31:0] m_base, m_limit, m_cur;
  logic [15:0] mem_img [int];
  int          b_addr[$];
  int          b_len[$];

  // Responder state
  int          resp_mode;  // 0 immediate, 1 random gaps, 2 accept then stall
  bit          in_burst;
  int          beats, cnt;
  int          cur_addr;

  // MemIF responder and per-cycle compare process
  initial begin : responder
    logic [15:0] e;
    bit          pv, pready;
    logic [31:0] paddr;
    logic [6:0]  plen;
    pv = 0; pready = 0; paddr = '0; plen = '0;
    mi_ready = 0; mi_wack = 0; mi_wlast = 0; in_burst = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mi_ready = 0; mi_wack = 0; mi_wlast = 0;
        in_burst = 0; pv = 0; pready = 0;
      end else begin
        if (pv && !pready) begin
          chk("valid_hold", mi_valid, 1);
          chk("addr_stable", mi_addr, paddr);
          chk("len_stable", mi_len, plen);
        end
        if (in_burst) chk("no_valid_in_data", mi_valid, 0);
        mi_ready = 0; mi_wack = 0; mi_wlast = 0;
        if (!in_burst) begin
          if (mi_valid && (resp_mode != 1 || $urandom_range(0, 2) == 0)) begin
            mi_ready = 1; in_burst = 1; cnt = 0;
            beats    = int'(mi_len) + 1;
            cur_addr = int'(mi_addr);
            chk("cmd_addr", mi_addr, m_cur);
            chk("cmd_rw", mi_rw, 0);
            chk("cmd_len_le_burst", beats <= BL, 1);
            chk("cmd_len_le_avail", beats <= exp_q.size(), 1);
            if (m_wrap) chk("cmd_len_le_room", beats <= int'(m_limit - m_cur), 1);
            b_addr.push_back(int'(mi_addr));
            b_len.push_back(int'(mi_len));
          end
        end else if (resp_mode == 0 || (resp_mode == 1 && $urandom_range(0, 1) == 1)) begin
          mi_wack  = 1;
          mi_wlast = (cnt == beats - 1);
          chk("data_avail", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("wdata", mi_wdata, e);
          end
          mem_img[cur_addr + cnt] = mi_wdata;
          cnt++;
          if (mi_wlast) begin
            in_burst = 0;
            m_cur = m_cur + beats;
            if (m_wrap && m_cur >= m_limit) m_cur = m_base;
            else m_cur = m_cur & ((32'd1 << AW) - 1);
          end
        end
        pv = mi_valid; pready = mi_ready; paddr = mi_addr; plen = mi_len;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit c, input int gap);
    @(negedge clk);
    pw_wdata = b; pw_wcmd = c; pw_wstb = 1;
    if (c) begin
      m_active = (b == 8'he0);
      m_have   = 0;
    end else if (m_active) begin
      if (!m_have) begin
        m_hi = b; m_have = 1;
      end else begin
        m_have = 0;
        if (!(m_cap && exp_q.size() >= FD)) exp_q.push_back({m_hi, b});
      end
    end
    @(negedge clk);
    pw_wstb = 0; pw_wcmd = 0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_end();
    @(negedge clk);
    pw_end = 1;
    @(negedge clk);
    pw_end = 0;
    m_active = 0; m_have = 0;
  endtask

  task automatic wb_xfer(input bit we, input logic [1:0] a, input logic [31:0] d,
                         output logic [31:0] rd);
    int lat;
    lat = -1; rd = '0;
    @(negedge clk);
    wb_cyc = 1; wb_we = we; wb_addr = a; wb_wdata = d;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (wb_ack) begin
        lat = i; rd = wb_rdata;
        break;
      end
    end
    chk("wb_ack_latency", lat, 0);
    @(negedge clk);
    chk("wb_ack_single", wb_ack, 0);
    wb_cyc = 0; wb_we = 0;
    if (we) begin
      case (a)
        2'd0: m_wrap  = d[1];
        2'd1: m_base  = d & ((32'd1 << AW) - 1);
        2'd2: m_limit = d & ((32'd1 << AW) - 1);
        2'd3: m_cur   = d & ((32'd1 << AW) - 1);
        default: ;
      endcase
    end
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(1'b1, a, d, dummy);
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] rd);
    wb_xfer(1'b0, a, 32'h0, rd);
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    bit done;
    done = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !in_burst && !mi_valid) begin
        done = 1;
        break;
      end
    end
    chk(name, done, 1);
    repeat (6) @(negedge clk);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_active = 0; m_have = 0; m_cap = 0; m_wrap = 0;
    m_base = '0; m_limit = '0; m_cur = '0; m_hi = '0;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] rd;
    int nb0, words;
    rst_n = 0; pw_wdata = '0; pw_wcmd = 0; pw_wstb = 0; pw_end = 0;
    wb_wdata = '0; wb_addr = '0; wb_we = 0; wb_cyc = 0; resp_mode = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_mi_valid", mi_valid, 0);
    chk("rst_wb_ack", wb_ack, 0);
    rst_n = 1;

    // Reset state readback
    wb_read(2'd0, rd); chk("rst_csr", rd, 32'h0);
    wb_read(2'd1, rd); chk("rst_base", rd, 32'h0);
    wb_read(2'd2, rd); chk("rst_limit", rd, 32'h0);
    wb_read(2'd3, rd); chk("rst_cur", rd, 32'h0);

    // Full burst
    wb_write(2'd1, 32'h100); wb_write(2'd3, 32'h100); wb_write(2'd0, 32'h1);
    wb_read(2'd1, rd); chk("base_rb", rd, 32'h100);
    nb0 = b_addr.size();
    send_byte(8'he0, 1, 0);
    for (int i = 0; i < 128; i++) send_byte(8'(i), 0, 0);
    wait_idle("full_drain", 2000);
    send_end();
    repeat (4) @(negedge clk);
    chk("full_nbursts", b_addr.size() - nb0, 1);
    chk("full_addr", b_addr[nb0], 32'h100);
    chk("full_len", b_len[nb0], 63);
    chk("full_w0", mem_img[32'h100], 16'h0001);
    chk("full_w1", mem_img[32'h101], 16'h0203);
    chk("full_w63", mem_img[32'h13f], 16'h7e7f);
    wb_read(2'd3, rd); chk("full_cur", rd, 32'h140);

    // Flush of a partial burst, even then odd byte count
    nb0 = b_addr.size();
    send_byte(8'he0, 1, 0);
    for (int i = 0; i < 10; i++) send_byte(8'(8'ha0 + i), 0, 0);
    send_end();
    wait_idle("flush_drain", 500);
    chk("flush_len", b_len[nb0], 4);
    chk("flush_addr", b_addr[nb0], 32'h140);
    chk("flush_w0", mem_img[32'h140], 16'ha0a1);
    chk("flush_w4", mem_img[32'h144], 16'ha8a9);
    send_byte(8'he0, 1, 0);
    for (int i = 0; i < 11; i++) send_byte(8'(8'hb0 + i), 0, 0);
    send_end();
    wait_idle("flush_odd_drain", 500);
    chk("flush_nbursts", b_addr.size() - nb0, 2);
    chk("flush_odd_len", b_len[nb0 + 1], 4);
    chk("flush_odd_w4", mem_img[32'h149], 16'hb8b9);
    wb_read(2'd3, rd); chk("flush_cur", rd, 32'h14a);

    // Ring window wrap
    wb_write(2'd1, 32'h1000); wb_write(2'd2, 32'h1050); wb_write(2'd3, 32'h1040);
    wb_write(2'd0, 32'h3);
    nb0 = b_addr.size();
    send_byte(8'he0, 1, 0);
    for (int i = 0; i < 128; i++) send_byte(8'(i), 0, 0);
    send_end();
    wait_idle("wrap_drain", 2000);
    chk("wrap_nbursts", b_addr.size() - nb0, 2);
    chk("wrap_addr0", b_addr[nb0], 32'h1040);
    chk("wrap_len0", b_len[nb0], 15);
    chk("wrap_addr1", b_addr[nb0 + 1], 32'h1000);
    chk("wrap_len1", b_len[nb0 + 1], 47);
    chk("wrap_w16", mem_img[32'h1000], 16'h2021);
    wb_read(2'd3, rd); chk("wrap_cur", rd, 32'h1030);

    // Overflow with DMA stopped, then drain
    wb_write(2'd0, 32'h0);
    m_cap = 1;
    send_byte(8'he0, 1, 0);
    for (int w = 0; w < FD + 2; w++) begin
      send_byte(8'(2 * w), 0, 0);
      send_byte(8'(2 * w + 1), 0, 0);
    end
    repeat (4) @(negedge clk);
    wb_read(2'd0, rd);
    chk("ovf_set", rd[3], 1);
    chk("ovf_level", rd[31:16], FD);
    chk("ovf_idle", rd[2], 0);
    wb_write(2'd0, 32'h8000_0000);
    wb_read(2'd0, rd);
    chk("ovf_clear", rd[3], 0);
    chk("ovf_level_kept", rd[31:16], FD);
    m_cap = 0;
    nb0 = b_addr.size();
    wb_write(2'd0, 32'h1);
    send_end();
    wait_idle("ovf_drain", 4000);
    chk("ovf_nbursts", b_addr.size() - nb0, 4);
    wb_read(2'd0, rd); chk("ovf_level_empty", rd[31:16], 0);

    // Handshake stress with concurrent SPI traffic
    wb_write(2'd1, 32'h2000); wb_write(2'd3, 32'h2000);
    resp_mode = 1;
    nb0 = b_addr.size();
    send_byte(8'he0, 1, 0);
    for (int i = 0; i < 400; i++) send_byte(8'($urandom), 0, $urandom_range(0, 3));
    send_end();
    wait_idle("stress_drain", 20000);
    words = 0;
    for (int i = nb0; i < b_len.size(); i++) words += b_len[i] + 1;
    chk("stress_words", words, 200);
    wb_read(2'd3, rd); chk("stress_cur", rd, 32'h20c8);
    wb_read(2'd0, rd); chk("stress_csr", rd, 32'h1);

    // Reset in the middle of a burst
    resp_mode = 2;
    send_byte(8'he0, 1, 0);
    for (int i = 0; i < 128; i++) send_byte(8'(i), 0, 0);
    for (int i = 0; i < 200; i++) begin
      if (in_burst) break;
      @(negedge clk);
    end
    chk("rstmid_in_burst", in_burst, 1);
    repeat (3) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("rstmid_valid", mi_valid, 0);
    repeat (2) @(negedge clk);
    model_reset();
    resp_mode = 0;
    rst_n = 1;
    wb_read(2'd0, rd); chk("rstmid_csr", rd, 32'h0);
    wb_read(2'd1, rd); chk("rstmid_base", rd, 32'h0);
    wb_read(2'd2, rd); chk("rstmid_limit", rd, 32'h0);
    wb_read(2'd3, rd); chk("rstmid_cur", rd, 32'h0);
    send_byte(8'h12, 0, 0);
    send_byte(8'h34, 0, 0);
    repeat (3) @(negedge clk);
    wb_read(2'd0, rd); chk("rstmid_stream_inactive", rd[31:16], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
